// File: rtl/aes_pkg.sv
// aes_pkg: shared types and pure-combinational helpers for the AES forward
// round datapath.
//   state_t     : 4x4 byte state, indexed [row][col]; FIPS byte k sits at
//                 [k%4][k/4]
//   NR_*        : round counts for AES-128/192/256
//   xtime       : multiply by x in GF(2^8)
//   shift_rows  : row n rotated left by n
//   mix_columns : per-column [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]
package aes_pkg;
  typedef logic [3:0][3:0][7:0] state_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam logic [7:0] RED_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
  endfunction

  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int n = 0; n < 4; n++)
      for (int c = 0; c < 4; c++)
        o[n][c] = s[n][2'(c + n)];
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
      // 3*b is expressed as xtime(b) ^ b
      o[0][c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[1][c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[2][c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[3][c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box, pure combinational lookup.
//   a : input byte
//   y : substituted byte
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
      8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
      8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
      8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
      8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
      8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
      8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
      8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
      8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
      8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
      8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
      8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
      8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
      8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
      8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
      8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
      8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
      8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
      8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
      8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
      8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
      8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
      8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
      8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
      8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
      8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
      8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
      8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
      8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
      8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
      8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
      8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
    endcase
  end
endmodule

// File: rtl/aes_enc_round_engine.sv
// aes_enc_round_engine: iterative AES forward cipher, one round per clock.
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready   : plaintext handshake, in_state[row][col]
//   rk_idx / rk           : round-key index driven from registered state;
//                           key store returns rk combinationally
//   out_valid / out_ready : ciphertext handshake, out_state = state register
// Parameter NR: 10, 12 or 14 rounds.
module aes_enc_round_engine
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][3:0][7:0]  in_state,
  output logic [3:0]            rk_idx,
  input  logic [3:0][3:0][7:0]  rk,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][3:0][7:0]  out_state
);
  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_nr_check
    $fatal(1, "aes_enc_round_engine: NR must be 10, 12 or 14");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] R_LAST  = 4'(NR);

  logic [1:0] fsm;
  logic [3:0] r;
  state_t     st, sb, sr, mc, nxt;

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      aes_sbox u_sbox (.a(st[i][j]), .y(sb[i][j]));
    end
  end

  always_comb begin
    sr  = shift_rows(sb);
    mc  = mix_columns(sr);
    // final round skips MixColumns
    nxt = ((r == R_LAST) ? sr : mc) ^ rk;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm <= S_IDLE;
      r   <= '0;
      st  <= '0;
    end else begin
      case (fsm)
        S_IDLE: if (in_valid) begin
          st  <= in_state ^ rk;
          r   <= 4'd1;
          fsm <= S_ROUND;
        end
        S_ROUND: begin
          st <= nxt;
          if (r == R_LAST) fsm <= S_DONE;
          else             r   <= r + 4'd1;
        end
        S_DONE: if (out_ready) begin
          r   <= '0;
          fsm <= S_IDLE;
        end
        default: begin
          r   <= '0;
          fsm <= S_IDLE;
        end
      endcase
    end
  end

  // all outputs decode registered state only
  assign in_ready  = (fsm == S_IDLE);
  assign out_valid = (fsm == S_DONE);
  assign rk_idx    = (fsm == S_DONE) ? R_LAST : (fsm == S_ROUND) ? r : 4'd0;
  assign out_state = st;
endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Scoreboard bench for aes_enc_round_engine: NR=10 and NR=14 instances,
// reference model derived from GF(2^8) arithmetic (S-box built from field
// inverse + affine map), FIPS-197 vectors plus randomized traffic.
module tb_aes_enc_round_engine;
  typedef logic [3:0][3:0][7:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic reset_n = 1'b0;
  logic in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
  logic in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
  logic [3:0] rk_idx_a, rk_idx_b;
  st_t in_state_a = '0, rk_a, out_state_a;
  st_t in_state_b = '0, rk_b, out_state_b;
  logic [127:0] ks_a [0:15];
  logic [127:0] ks_b [0:15];

  int checks = 0, errors = 0;
  int last_out_a = -1;
  int bp_a = 0; // 0 ready, 1 stall, 2 random
  logic [127:0] q_a[$], q_b[$];

  // ---------------- reference model ----------------
  logic [7:0]   sb_m [0:255];
  logic [127:0] kx   [0:14];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int k = 14; k >= 8; k--) if (p[k]) p ^= 15'h11b << (k - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      sb_m[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) kx[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // FIPS byte k = s[k], row k%4, column k/4; runs 'upto' rounds
  function automatic logic [127:0] enc(input logic [127:0] pt, input int nr, input int upto);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ kx[0][127-8*k -: 8];
    for (int rd = 1; rd <= upto; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb_m[s[k]];
      for (int k = 0; k < 16; k++) s[k] = t[(k%4) + 4*(((k/4) + (k%4)) % 4)];
      if (rd < nr)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      for (int k = 0; k < 16; k++) s[k] ^= kx[rd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  function automatic st_t to_st(input logic [127:0] f);
    st_t s;
    for (int k = 0; k < 16; k++) s[k%4][k/4] = f[127-8*k -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_st(input st_t s);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[127-8*k -: 8] = s[k%4][k/4];
    return f;
  endfunction

  // ---------------- DUTs ----------------
  assign rk_a = to_st(ks_a[rk_idx_a]);
  assign rk_b = to_st(ks_b[rk_idx_b]);

  aes_enc_round_engine #(.NR(10)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_state(in_state_a), .rk_idx(rk_idx_a), .rk(rk_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_state(out_state_a));

  aes_enc_round_engine #(.NR(14)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_state(in_state_b), .rk_idx(rk_idx_b), .rk(rk_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_state(out_state_b));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) if (reset_n && out_valid_a && out_ready_a) begin
    if (q_a.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_a_unexpected: got %h expected no output", from_st(out_state_a));
    end else chk("sb_a_ct", from_st(out_state_a), q_a.pop_front());
    last_out_a = cyc;
  end

  always @(negedge clk) if (reset_n && out_valid_b && out_ready_b) begin
    if (q_b.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_b_unexpected: got %h expected no output", from_st(out_state_b));
    end else chk("sb_b_ct", from_st(out_state_b), q_b.pop_front());
  end

  always @(posedge clk) begin
    #1;
    case (bp_a)
      0:       out_ready_a = 1'b1;
      1:       out_ready_a = 1'b0;
      default: out_ready_a = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [127:0] pt, input logic [127:0] exp, input logic hold,
                        output int acc);
    @(posedge clk); #1;
    in_state_a = to_st(pt);
    in_valid_a = 1'b1;
    acc = -1;
    for (int i = 0; i < 300 && acc < 0; i++) begin
      @(negedge clk);
      if (in_ready_a) acc = cyc;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL send_a_timeout: got no in_ready expected in_ready within 300 cycles");
    end else q_a.push_back(exp);
    @(posedge clk); #1;
    if (!hold) in_valid_a = 1'b0;
  endtask

  task automatic trace_a(input logic chk_mid, input logic [127:0] mid);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j <= 10) begin
        chk("trace_rk_idx", 128'(rk_idx_a), 128'(j));
        chk("trace_no_valid", 128'(out_valid_a), 128'(0));
      end else begin
        chk("latency_valid", 128'(out_valid_a), 128'(1));
        chk("done_rk_idx", 128'(rk_idx_a), 128'(10));
      end
      if (j == 1) chk("busy_in_ready", 128'(in_ready_a), 128'(0));
      if (j == 2 && chk_mid) chk("round1_state", from_st(out_state_a), mid);
    end
  endtask

  task automatic drain_a();
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (q_a.size() == 0 && in_ready_a) break;
    end
    if (i == 600) begin
      checks++; errors++;
      $display("FAIL drain_a_timeout: got %0d pending expected 0", q_a.size());
    end
  endtask

  task automatic load_a();
    for (int r = 0; r <= 10; r++) ks_a[r] = kx[r];
  endtask

  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] MID_B = 128'ha49c7ff2689f352b6b5bea43026a5049;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, v;
    logic [127:0] p1, p2, k;
    for (int i = 0; i < 16; i++) begin ks_a[i] = '0; ks_b[i] = '0; end
    build_sbox();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready_a), 128'(1));
    chk("rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("rst_out_state", from_st(out_state_a), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx_a), 128'(0));
    @(posedge clk); #1 reset_n = 1'b1;

    // FIPS-197 C.1 with full trace
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    load_a();
    send_a(PT_C, CT_C1, 1'b0, acc);
    trace_a(1'b0, '0);
    drain_a();

    // FIPS-197 Appendix B, round-1 state and rk_idx sequence
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    load_a();
    @(negedge clk);
    chk("idle_rk_idx", 128'(rk_idx_a), 128'(0));
    send_a(PT_B, CT_B, 1'b0, acc);
    trace_a(1'b1, MID_B);
    drain_a();

    // backpressure in DONE, stray in_valid ignored
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    load_a();
    bp_a = 1;
    send_a(PT_C, CT_C1, 1'b0, acc);
    v = -1;
    for (int i = 0; i < 30 && v < 0; i++) begin
      @(negedge clk);
      if (out_valid_a) v = cyc;
    end
    chk("bp_latency", 128'(v - (acc + 1)), 128'(10));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 128'(out_valid_a), 128'(1));
      chk("bp_state_held", from_st(out_state_a), CT_C1);
      chk("bp_in_ready", 128'(in_ready_a), 128'(0));
      in_valid_a = (i == 2);
      if (i == 2) in_state_a = to_st({$urandom, $urandom, $urandom, $urandom});
    end
    in_valid_a = 1'b0;
    bp_a = 0;
    drain_a();
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_capture", 128'(out_valid_a), 128'(0));
    end

    // back-to-back with in_valid held high
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    send_a(p1, enc(p1, 10, 10), 1'b1, acc);
    send_a(p2, enc(p2, 10, 10), 1'b0, acc2);
    chk("b2b_gap", 128'(acc2 - last_out_a), 128'(1));
    drain_a();

    // reset at r=5 discards the block
    send_a(PT_C, CT_C1, 1'b0, acc);
    for (int j = 1; j <= 5; j++) @(negedge clk);
    chk("pre_reset_rk_idx", 128'(rk_idx_a), 128'(5));
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    q_a.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready_a), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("mid_rst_state", from_st(out_state_a), 128'(0));
    chk("mid_rst_rk_idx", 128'(rk_idx_a), 128'(0));
    send_a(PT_C, CT_C1, 1'b0, acc);
    drain_a();

    // randomized keys/plaintexts with random out_ready
    for (int kk = 0; kk < 3; kk++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand({k, 128'h0}, 4, 10);
      load_a();
      bp_a = 2;
      for (int b = 0; b < 6; b++) begin
        p1 = {$urandom, $urandom, $urandom, $urandom};
        send_a(p1, enc(p1, 10, 10), 1'b0, acc);
      end
      drain_a();
      bp_a = 0;
    end

    // NR=14, FIPS-197 C.3
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) ks_b[r] = kx[r];
    @(posedge clk); #1;
    in_state_b = to_st(PT_C);
    in_valid_b = 1'b1;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (in_ready_b) acc = cyc;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL send_b_timeout: got no in_ready expected in_ready");
    end else q_b.push_back(CT_C3);
    @(posedge clk); #1 in_valid_b = 1'b0;
    v = -1;
    for (int i = 0; i < 40 && v < 0; i++) begin
      @(negedge clk);
      if (out_valid_b) v = cyc;
    end
    chk("b_latency", 128'(v - (acc + 1)), 128'(14));
    chk("b_done_rk_idx", 128'(rk_idx_b), 128'(14));
    repeat (3) @(negedge clk);
    chk("b_queue_empty", 128'(q_b.size()), 128'(0));
    chk("a_queue_empty", 128'(q_a.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
